// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared widths and source encodings for the common data bus arbiter.
//   ROB_POS_W / DATA_W / ADDR_W are the default payload widths; the
//   CDB_SRC_* constants encode which producer owns a broadcast.
package cdb_arbiter_pkg;

  localparam int ROB_POS_W = 4;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo
//   Small skid FIFO for one CDB producer. Storage is a plain array that is
//   never cleared; only pointers and count are reset/flushed.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         synchronous clear of pointers and count
//   push          write push_data at the tail (caller guarantees not full)
//   pop           drop the head entry (caller guarantees not empty)
//   count         number of stored entries (0..DEPTH)
//   head          data at the head of the queue
module cdb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)
        count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push)
        count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the common data bus between the ALU and the load/store buffer.
//   Each producer feeds a skid FIFO; a round-robin grant pops one head per
//   cycle and registers it onto the cdb_* outputs. rollback flushes both
//   FIFOs; rdy=0 freezes everything.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rdy                      global enable (low = hold all state)
//   rollback                 flush all pending results
//   alu_valid/rob_pos/val/jump/pc, alu_ready   ALU result input
//   lsb_valid/rob_pos/val, lsb_ready            LSB result input
//   cdb_valid/src/rob_pos/val/jump/pc           registered broadcast
// Optional build macro CDB_ARB_STATS_EN adds stat_alu_grants,
//   stat_lsb_grants and stat_stall_cycles (32-bit, cleared by rst only).
module cdb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_POS_W  = cdb_arbiter_pkg::ROB_POS_W,
  parameter int DATA_W     = cdb_arbiter_pkg::DATA_W,
  parameter int ADDR_W     = cdb_arbiter_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_valid,
  input  logic [ROB_POS_W-1:0] alu_rob_pos,
  input  logic [DATA_W-1:0]    alu_val,
  input  logic                 alu_jump,
  input  logic [ADDR_W-1:0]    alu_pc,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [ROB_POS_W-1:0] lsb_rob_pos,
  input  logic [DATA_W-1:0]    lsb_val,
  output logic                 lsb_ready,
  output logic                 cdb_valid,
  output logic                 cdb_src,
  output logic [ROB_POS_W-1:0] cdb_rob_pos,
  output logic [DATA_W-1:0]    cdb_val,
  output logic                 cdb_jump,
  output logic [ADDR_W-1:0]    cdb_pc
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]          stat_alu_grants,
  output logic [31:0]          stat_lsb_grants,
  output logic [31:0]          stat_stall_cycles
`endif
);

  import cdb_arbiter_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ALU_W = ROB_POS_W + DATA_W + 1 + ADDR_W;
  localparam int LSB_W = ROB_POS_W + DATA_W;

  logic [CNT_W-1:0] alu_count;
  logic [CNT_W-1:0] lsb_count;
  logic [ALU_W-1:0] alu_head;
  logic [LSB_W-1:0] lsb_head;

  logic [ROB_POS_W-1:0] alu_head_pos;
  logic [DATA_W-1:0]    alu_head_val;
  logic                 alu_head_jump;
  logic [ADDR_W-1:0]    alu_head_pc;
  logic [ROB_POS_W-1:0] lsb_head_pos;
  logic [DATA_W-1:0]    lsb_head_val;

  logic active;
  logic flush;
  logic alu_push;
  logic lsb_push;
  logic alu_nonempty;
  logic lsb_nonempty;
  logic grant_alu;
  logic grant_lsb;

  logic                 rr_last_reg;
  logic                 cdb_valid_reg;
  logic                 cdb_src_reg;
  logic [ROB_POS_W-1:0] cdb_rob_pos_reg;
  logic [DATA_W-1:0]    cdb_val_reg;
  logic                 cdb_jump_reg;
  logic [ADDR_W-1:0]    cdb_pc_reg;

  assign active = rdy && !rollback;
  assign flush  = rdy && rollback;

  // Ready looks only at the registered count: a full FIFO stays not-ready
  // even in a cycle where it is about to be popped.
  assign alu_ready = active && (alu_count < CNT_W'(FIFO_DEPTH));
  assign lsb_ready = active && (lsb_count < CNT_W'(FIFO_DEPTH));
  assign alu_push  = alu_valid && alu_ready;
  assign lsb_push  = lsb_valid && lsb_ready;

  // Grant decisions use pre-push counts, so a result pushed into an empty
  // FIFO waits at least one cycle before it can be broadcast.
  assign alu_nonempty = (alu_count != '0);
  assign lsb_nonempty = (lsb_count != '0);
  assign grant_alu = active && alu_nonempty &&
                     (!lsb_nonempty || rr_last_reg == CDB_SRC_LSB);
  assign grant_lsb = active && lsb_nonempty &&
                     (!alu_nonempty || rr_last_reg == CDB_SRC_ALU);

  cdb_fifo #(.WIDTH(ALU_W), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (alu_push),
    .push_data ({alu_rob_pos, alu_val, alu_jump, alu_pc}),
    .pop       (grant_alu),
    .count     (alu_count),
    .head      (alu_head)
  );

  cdb_fifo #(.WIDTH(LSB_W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (lsb_push),
    .push_data ({lsb_rob_pos, lsb_val}),
    .pop       (grant_lsb),
    .count     (lsb_count),
    .head      (lsb_head)
  );

  assign {alu_head_pos, alu_head_val, alu_head_jump, alu_head_pc} = alu_head;
  assign {lsb_head_pos, lsb_head_val} = lsb_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_reg     <= CDB_SRC_LSB;
      cdb_valid_reg   <= 1'b0;
      cdb_src_reg     <= CDB_SRC_ALU;
      cdb_rob_pos_reg <= '0;
      cdb_val_reg     <= '0;
      cdb_jump_reg    <= 1'b0;
      cdb_pc_reg      <= '0;
    end else if (rdy) begin
      if (rollback) begin
        rr_last_reg   <= CDB_SRC_LSB;
        cdb_valid_reg <= 1'b0;
      end else if (grant_alu) begin
        rr_last_reg     <= CDB_SRC_ALU;
        cdb_valid_reg   <= 1'b1;
        cdb_src_reg     <= CDB_SRC_ALU;
        cdb_rob_pos_reg <= alu_head_pos;
        cdb_val_reg     <= alu_head_val;
        cdb_jump_reg    <= alu_head_jump;
        cdb_pc_reg      <= alu_head_pc;
      end else if (grant_lsb) begin
        rr_last_reg     <= CDB_SRC_LSB;
        cdb_valid_reg   <= 1'b1;
        cdb_src_reg     <= CDB_SRC_LSB;
        cdb_rob_pos_reg <= lsb_head_pos;
        cdb_val_reg     <= lsb_head_val;
        cdb_jump_reg    <= 1'b0;
        cdb_pc_reg      <= '0;
      end else begin
        cdb_valid_reg <= 1'b0;
      end
    end
  end

  assign cdb_valid   = cdb_valid_reg;
  assign cdb_src     = cdb_src_reg;
  assign cdb_rob_pos = cdb_rob_pos_reg;
  assign cdb_val     = cdb_val_reg;
  assign cdb_jump    = cdb_jump_reg;
  assign cdb_pc      = cdb_pc_reg;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_alu_grants_reg;
  logic [31:0] stat_lsb_grants_reg;
  logic [31:0] stat_stall_cycles_reg;

  // A stall is any enabled cycle where some FIFO holds data it did not get
  // to broadcast; counted once per cycle regardless of how many FIFOs wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_alu_grants_reg   <= '0;
      stat_lsb_grants_reg   <= '0;
      stat_stall_cycles_reg <= '0;
    end else if (rdy) begin
      if (grant_alu) stat_alu_grants_reg <= stat_alu_grants_reg + 32'd1;
      if (grant_lsb) stat_lsb_grants_reg <= stat_lsb_grants_reg + 32'd1;
      if ((alu_nonempty && !grant_alu) || (lsb_nonempty && !grant_lsb))
        stat_stall_cycles_reg <= stat_stall_cycles_reg + 32'd1;
    end
  end

  assign stat_alu_grants   = stat_alu_grants_reg;
  assign stat_lsb_grants   = stat_lsb_grants_reg;
  assign stat_stall_cycles = stat_stall_cycles_reg;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed stimulus against a queue-based reference model of the CDB
//   arbiter; outputs are compared every cycle, plus literal expectations
//   for each scenario.
module tb_cdb_arbiter;

  localparam int D = 4;

  typedef struct packed {
    logic [3:0]  pos;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } res_t;

  typedef struct packed {
    logic        src;
    logic [3:0]  pos;
    logic [31:0] val;
  } log_t;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        alu_valid;
  logic [3:0]  alu_rob_pos;
  logic [31:0] alu_val;
  logic        alu_jump;
  logic [31:0] alu_pc;
  logic        alu_ready;
  logic        lsb_valid;
  logic [3:0]  lsb_rob_pos;
  logic [31:0] lsb_val;
  logic        lsb_ready;
  logic        cdb_valid;
  logic        cdb_src;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;
  logic        cdb_jump;
  logic [31:0] cdb_pc;
`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_alu_grants;
  logic [31:0] stat_lsb_grants;
  logic [31:0] stat_stall_cycles;
`endif

  cdb_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .alu_valid   (alu_valid),
    .alu_rob_pos (alu_rob_pos),
    .alu_val     (alu_val),
    .alu_jump    (alu_jump),
    .alu_pc      (alu_pc),
    .alu_ready   (alu_ready),
    .lsb_valid   (lsb_valid),
    .lsb_rob_pos (lsb_rob_pos),
    .lsb_val     (lsb_val),
    .lsb_ready   (lsb_ready),
    .cdb_valid   (cdb_valid),
    .cdb_src     (cdb_src),
    .cdb_rob_pos (cdb_rob_pos),
    .cdb_val     (cdb_val),
    .cdb_jump    (cdb_jump),
    .cdb_pc      (cdb_pc)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_alu_grants   (stat_alu_grants),
    .stat_lsb_grants   (stat_lsb_grants),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  res_t  aq[$];
  res_t  lq[$];
  bit    rr_lsb = 1'b1;
  bit    edge_rdy = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_src = 1'b0;
  logic [3:0]  exp_pos = '0;
  logic [31:0] exp_val = '0;
  logic        exp_jump = 1'b0;
  logic [31:0] exp_pc = '0;

  log_t  blog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock edge of the arbiter as described in words: grant from the
  // contents before this edge, then accept new results if there was room.
  task automatic model_step();
    res_t r;
    bit take_a, take_l, acc_a, acc_l;
    edge_rdy = 1'b0;
    if (rst) begin
      aq.delete(); lq.delete();
      rr_lsb = 1'b1;
      exp_valid = 0; exp_src = 0; exp_pos = 0; exp_val = 0; exp_jump = 0; exp_pc = 0;
    end else if (rdy) begin
      if (rollback) begin
        aq.delete(); lq.delete();
        rr_lsb = 1'b1;
        exp_valid = 0;
      end else begin
        edge_rdy = 1'b1;
        acc_a  = alu_valid && (aq.size() < D);
        acc_l  = lsb_valid && (lq.size() < D);
        take_a = (aq.size() != 0) && ((lq.size() == 0) || rr_lsb);
        take_l = !take_a && (lq.size() != 0);
        if (take_a) begin
          r = aq.pop_front();
          exp_valid = 1; exp_src = 0; exp_pos = r.pos; exp_val = r.val;
          exp_jump = r.jump; exp_pc = r.pc;
          rr_lsb = 1'b0;
        end else if (take_l) begin
          r = lq.pop_front();
          exp_valid = 1; exp_src = 1; exp_pos = r.pos; exp_val = r.val;
          exp_jump = 0; exp_pc = 0;
          rr_lsb = 1'b1;
        end else begin
          exp_valid = 0;
        end
        if (acc_a) aq.push_back('{alu_rob_pos, alu_val, alu_jump, alu_pc});
        if (acc_l) lq.push_back('{lsb_rob_pos, lsb_val, 1'b0, 32'h0});
      end
    end
  endtask

  // Single compare process: model advances at the edge, DUT checked 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("cdb_valid", 64'(cdb_valid), 64'(exp_valid));
      chk("alu_ready", 64'(alu_ready), 64'(rdy && !rollback && aq.size() < D));
      chk("lsb_ready", 64'(lsb_ready), 64'(rdy && !rollback && lsb_q_room()));
      if (exp_valid) begin
        chk("cdb_src", 64'(cdb_src), 64'(exp_src));
        chk("cdb_rob_pos", 64'(cdb_rob_pos), 64'(exp_pos));
        chk("cdb_val", 64'(cdb_val), 64'(exp_val));
        chk("cdb_jump", 64'(cdb_jump), 64'(exp_jump));
        chk("cdb_pc", 64'(cdb_pc), 64'(exp_pc));
      end
      if (edge_rdy && cdb_valid)
        blog.push_back('{cdb_src, cdb_rob_pos, cdb_val});
    end
  end

  function automatic bit lsb_q_room();
    return lq.size() < D;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  bit saw_alu_full;

  initial begin
    rst = 1; rdy = 1; rollback = 0;
    alu_valid = 0; alu_rob_pos = 0; alu_val = 0; alu_jump = 0; alu_pc = 0;
    lsb_valid = 0; lsb_rob_pos = 0; lsb_val = 0;
    idle(3);

    // Reset state
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    chk("rst_pos", 64'(cdb_rob_pos), 64'd0);
    chk("rst_val", 64'(cdb_val), 64'd0);
    chk("rst_jump", 64'(cdb_jump), 64'd0);
    chk("rst_pc", 64'(cdb_pc), 64'd0);
    rst = 0;
    idle(1);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_lsb_ready", 64'(lsb_ready), 64'd1);

    // 1: single ALU push, one-cycle latency, one-cycle pulse
    alu_valid = 1; alu_rob_pos = 4'd3; alu_val = 32'h11; alu_jump = 0; alu_pc = 0;
    idle(1);
    alu_valid = 0;
    idle(1);
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_src", 64'(cdb_src), 64'd0);
    chk("t1_pos", 64'(cdb_rob_pos), 64'd3);
    chk("t1_val", 64'(cdb_val), 64'h11);
    idle(1);
    chk("t1_valid_drop", 64'(cdb_valid), 64'd0);

    // Rollback restores the ALU-first tie break
    rollback = 1; idle(1); rollback = 0;
    blog.delete();

    // 2: both sources every cycle for 6 cycles -> strict alternation
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_rob_pos = 4'(i); alu_val = 32'h200 + 32'(i);
      alu_jump = 1'(i); alu_pc = 32'h4000 + 32'(i);
      lsb_valid = 1; lsb_rob_pos = 4'(8 + i); lsb_val = 32'h300 + 32'(i);
      idle(1);
    end
    alu_valid = 0; lsb_valid = 0;
    idle(10);
    chk("t2_count", 64'(blog.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (blog.size() > i)
        chk("t2_order", 64'({blog[i].src, blog[i].pos}),
            64'({1'(i % 2), 4'((i % 2) ? 8 + i / 2 : i / 2)}));
    end

    // 3: saturate the ALU FIFO, including pushes while not ready (dropped)
    saw_alu_full = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = 1; alu_rob_pos = 4'(c); alu_val = 32'h500 + 32'(c);
      alu_jump = 0; alu_pc = 32'h8000 + 32'(c);
      lsb_valid = 1; lsb_rob_pos = 4'(c); lsb_val = 32'h600 + 32'(c);
      #1;
      if (!alu_ready) saw_alu_full = 1;
      idle(1);
    end
    alu_valid = 0; lsb_valid = 0;
    idle(12);
    chk("t3_alu_full_seen", 64'(saw_alu_full), 64'd1);

    // 4: fill both FIFOs, then rollback
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_rob_pos = 4'(c); alu_val = 32'h700 + 32'(c);
      lsb_valid = 1; lsb_rob_pos = 4'(c); lsb_val = 32'h800 + 32'(c);
      idle(1);
    end
    alu_valid = 0; lsb_valid = 0;
    rollback = 1; idle(1); rollback = 0;
    #1;
    chk("t4_valid", 64'(cdb_valid), 64'd0);
    chk("t4_alu_ready", 64'(alu_ready), 64'd1);
    chk("t4_lsb_ready", 64'(lsb_ready), 64'd1);
    blog.delete();
    idle(8);
    chk("t4_no_stale", 64'(blog.size()), 64'd0);

    // 5: freeze with rdy=0 while a broadcast is up and one result waits
    alu_valid = 1; alu_rob_pos = 4'd5; alu_val = 32'hA5; alu_jump = 1; alu_pc = 32'h1234;
    lsb_valid = 1; lsb_rob_pos = 4'd9; lsb_val = 32'hB9;
    idle(1);
    alu_valid = 0; lsb_valid = 0;
    idle(1);
    rdy = 0;
    #1;
    chk("t5_alu_ready", 64'(alu_ready), 64'd0);
    chk("t5_lsb_ready", 64'(lsb_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      idle(1);
      chk("t5_frozen_valid", 64'(cdb_valid), 64'd1);
      chk("t5_frozen_pos", 64'({cdb_src, cdb_rob_pos}), 64'({1'b0, 4'd5}));
    end
    rdy = 1;
    idle(4);
    chk("t5_count", 64'(blog.size()), 64'd2);
    if (blog.size() == 2) begin
      chk("t5_first", 64'({blog[0].src, blog[0].pos, blog[0].val}), 64'({1'b0, 4'd5, 32'hA5}));
      chk("t5_second", 64'({blog[1].src, blog[1].pos, blog[1].val}), 64'({1'b1, 4'd9, 32'hB9}));
    end

    // 6: ten sequential ALU results across a pointer wrap
    blog.delete();
    for (int i = 0; i < 10; i++) begin
      alu_valid = 1; alu_rob_pos = 4'(i); alu_val = 32'h100 + 32'(i);
      alu_jump = 1'(i); alu_pc = 32'h1000 + 32'(4 * i);
      idle(1);
    end
    alu_valid = 0;
    idle(4);
    chk("t6_count", 64'(blog.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (blog.size() > i)
        chk("t6_order", 64'({blog[i].src, blog[i].pos, blog[i].val}),
            64'({1'b0, 4'(i), 32'h100 + 32'(i)}));
    end

    // 7: reset mid-operation discards queued results
    alu_valid = 1; alu_rob_pos = 4'd1; alu_val = 32'hC1;
    lsb_valid = 1; lsb_rob_pos = 4'd2; lsb_val = 32'hC2;
    idle(1);
    alu_valid = 0; lsb_valid = 0;
    rst = 1; idle(1); rst = 0;
    chk("t7_valid", 64'(cdb_valid), 64'd0);
    blog.delete();
    idle(5);
    chk("t7_discarded", 64'(blog.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
